// File: rtl/mmsa_pkg.sv
// Shared types, encodings and defaults for the MMSA host-side transmitter.
package mmsa_pkg;

   localparam int unsigned ELEM_W_DEF  = 8;
   localparam int unsigned NUM_MAT_DEF = 32;
   localparam int unsigned IDX_W_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_LOAD,
      ST_IDX,
      ST_WAIT,
      ST_GAP
   } state_t;

   localparam logic [1:0] SZ_2   = 2'd0;
   localparam logic [1:0] SZ_4   = 2'd1;
   localparam logic [1:0] SZ_8   = 2'd2;
   localparam logic [1:0] SZ_BAD = 2'd3;

   localparam logic CMD_LOAD = 1'b0;
   localparam logic CMD_IDX  = 1'b1;

   function automatic int unsigned size_n2(input logic [1:0] sz);
      case (sz)
         SZ_2:    return 4;
         SZ_4:    return 16;
         SZ_8:    return 64;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/mmsa_piso.sv
// Parallel-in/serial-out shifter, MSB first; zeros fill from the LSB side.
module mmsa_piso #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_data,
   output logic         o_msb
);

   logic [W-1:0] r_sr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= i_data;
      end else if (i_shift) begin
         r_sr <= r_sr << 1;
      end
   end

   assign o_msb = r_sr[W-1];

endmodule

// File: rtl/mmsa_host_tx.sv
// Host transmitter: serializes matrix loads and index commands onto the
// MMSA core's bit-serial input link.
module mmsa_host_tx
   import mmsa_pkg::*;
#(
   parameter int unsigned ELEM_W  = ELEM_W_DEF,
   parameter int unsigned NUM_MAT = NUM_MAT_DEF,
   parameter int unsigned IDX_W   = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_type,
   input  logic [1:0]        cmd_size,
   input  logic [IDX_W-1:0]  cmd_i_idx,
   input  logic [IDX_W-1:0]  cmd_w_idx,
   input  logic              elem_valid,
   output logic              elem_ready,
   input  logic [ELEM_W-1:0] elem_data,
   input  logic              rsp_done,
   output logic              in_valid,
   output logic              matrix,
   output logic [1:0]        matrix_size,
   output logic              in_valid2,
   output logic              i_mat_idx,
   output logic              w_mat_idx,
   output logic              busy,
   output logic [1:0]        err
);

   localparam int unsigned TOT_MAX = NUM_MAT * 64;
   localparam int unsigned EC_W    = $clog2(TOT_MAX);
   localparam int unsigned RC_W    = $clog2(TOT_MAX + 1);
   localparam int unsigned BC_W    = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;
   localparam int unsigned IC_W    = (IDX_W > 1) ? $clog2(IDX_W) : 1;

   state_t              r_state;
   state_t              w_nstate;
   logic [1:0]          r_size;
   logic [BC_W-1:0]     r_bit_cnt, w_bit_n;
   logic [EC_W-1:0]     r_elem_cnt, w_elem_n;
   logic [IC_W-1:0]     r_idx_cnt, w_idx_n;
   logic [RC_W-1:0]     r_req_cnt, w_req_n;
   logic [RC_W-1:0]     w_total;
   logic [ELEM_W-1:0]   r_hold;
   logic                r_hold_full, w_hold_full_n;
   logic                r_cmd_ready, r_elem_ready, r_in_valid, r_in_valid2, r_busy;
   logic [1:0]          r_msize, r_err;
   logic                w_er_n;
   logic                w_cmd_acc, w_elem_acc, w_last_bit, w_last_elem;
   logic                w_sh_load, w_sh_shift, w_ix_load, w_ix_shift, w_underrun;
   logic [ELEM_W-1:0]   w_sh_data;

   assign w_cmd_acc   = r_cmd_ready & cmd_valid;
   assign w_elem_acc  = r_elem_ready & elem_valid;
   assign w_total     = RC_W'(NUM_MAT * size_n2(r_size));
   assign w_last_bit  = (r_bit_cnt == BC_W'(ELEM_W - 1));
   assign w_last_elem = (r_elem_cnt == EC_W'(w_total - RC_W'(1)));

   always_comb begin
      w_nstate   = r_state;
      w_sh_load  = 1'b0;
      w_sh_shift = 1'b0;
      w_sh_data  = '0;
      w_ix_load  = 1'b0;
      w_ix_shift = 1'b0;
      w_underrun = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_acc) begin
               if (cmd_type == CMD_IDX) begin
                  w_nstate  = ST_IDX;
                  w_ix_load = 1'b1;
               end else if (cmd_size == SZ_BAD) begin
                  w_nstate = ST_GAP;
               end else begin
                  w_nstate = ST_PRIME;
               end
            end
         end
         ST_PRIME: begin
            if (w_elem_acc) begin
               w_nstate  = ST_LOAD;
               w_sh_load = 1'b1;
               w_sh_data = elem_data;
            end
         end
         ST_LOAD: begin
            if (!w_last_bit) begin
               w_sh_shift = 1'b1;
            end else if (w_last_elem) begin
               // final shift leaves the shifter all-zero, so matrix idles low
               w_sh_shift = 1'b1;
               w_nstate   = ST_GAP;
            end else begin
               w_sh_load = 1'b1;
               if (r_hold_full) w_sh_data = r_hold;
               else             w_underrun = 1'b1;
            end
         end
         ST_IDX: begin
            w_ix_shift = 1'b1;
            if (r_idx_cnt == IC_W'(IDX_W - 1)) w_nstate = ST_WAIT;
         end
         ST_WAIT: begin
            if (rsp_done) w_nstate = ST_GAP;
         end
         ST_GAP:  w_nstate = ST_IDLE;
         default: w_nstate = ST_IDLE;
      endcase
   end

   always_comb begin
      w_hold_full_n = r_hold_full;
      w_req_n       = r_req_cnt;
      w_bit_n       = '0;
      w_elem_n      = '0;
      w_idx_n       = '0;
      // req_cnt counts element slots already claimed, including zero-filled ones
      if (r_state == ST_LOAD && w_sh_load) begin
         w_hold_full_n = 1'b0;
         if (!r_hold_full) w_req_n = w_req_n + RC_W'(1);
      end
      if (w_elem_acc) begin
         w_req_n = w_req_n + RC_W'(1);
         if (r_state == ST_LOAD) w_hold_full_n = 1'b1;
      end
      if (w_cmd_acc) begin
         w_req_n       = '0;
         w_hold_full_n = 1'b0;
      end
      if (r_state == ST_LOAD && w_nstate == ST_LOAD) begin
         w_bit_n  = w_last_bit ? '0 : r_bit_cnt + BC_W'(1);
         w_elem_n = w_last_bit ? r_elem_cnt + EC_W'(1) : r_elem_cnt;
      end
      if (r_state == ST_IDX && w_nstate == ST_IDX) w_idx_n = r_idx_cnt + IC_W'(1);
      // a full holding register may still accept on a boundary cycle, since it hands off then
      w_er_n = (w_nstate == ST_PRIME) ||
               ((w_nstate == ST_LOAD) && (w_req_n < w_total) &&
                (!w_hold_full_n || (w_bit_n == BC_W'(ELEM_W - 1))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_size       <= '0;
         r_bit_cnt    <= '0;
         r_elem_cnt   <= '0;
         r_idx_cnt    <= '0;
         r_req_cnt    <= '0;
         r_hold       <= '0;
         r_hold_full  <= 1'b0;
         r_cmd_ready  <= 1'b0;
         r_elem_ready <= 1'b0;
         r_in_valid   <= 1'b0;
         r_msize      <= '0;
         r_in_valid2  <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= '0;
      end else begin
         r_state      <= w_nstate;
         if (w_cmd_acc) r_size <= cmd_size;
         if (w_elem_acc && r_state == ST_LOAD) r_hold <= elem_data;
         r_hold_full  <= w_hold_full_n;
         r_req_cnt    <= w_req_n;
         r_bit_cnt    <= w_bit_n;
         r_elem_cnt   <= w_elem_n;
         r_idx_cnt    <= w_idx_n;
         r_cmd_ready  <= (w_nstate == ST_IDLE);
         r_busy       <= (w_nstate != ST_IDLE);
         r_elem_ready <= w_er_n;
         r_in_valid   <= (w_nstate == ST_LOAD);
         r_msize      <= (r_state == ST_PRIME && w_nstate == ST_LOAD) ? r_size : '0;
         r_in_valid2  <= (w_nstate == ST_IDX);
         if (w_cmd_acc)       r_err    <= {1'b0, (cmd_type == CMD_LOAD) && (cmd_size == SZ_BAD)};
         else if (w_underrun) r_err[1] <= 1'b1;
      end
   end

   mmsa_piso #(.W(ELEM_W)) u_elem_piso (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_sh_load),
      .i_shift (w_sh_shift),
      .i_data  (w_sh_data),
      .o_msb   (matrix)
   );

   mmsa_piso #(.W(IDX_W)) u_i_piso (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_ix_load),
      .i_shift (w_ix_shift),
      .i_data  (cmd_i_idx),
      .o_msb   (i_mat_idx)
   );

   mmsa_piso #(.W(IDX_W)) u_w_piso (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_ix_load),
      .i_shift (w_ix_shift),
      .i_data  (cmd_w_idx),
      .o_msb   (w_mat_idx)
   );

   assign cmd_ready   = r_cmd_ready;
   assign elem_ready  = r_elem_ready;
   assign in_valid    = r_in_valid;
   assign matrix_size = r_msize;
   assign in_valid2   = r_in_valid2;
   assign busy        = r_busy;
   assign err         = r_err;

endmodule

// File: doc/mmsa_host_tx.md
# mmsa_host_tx

Host-side transmitter that drives the bit-serial input protocol of the MMSA matrix core. It takes parallel commands and element bytes from the test/host fabric and serializes them onto the core's `in_valid`/`matrix`/`matrix_size` (load phase) and `in_valid2`/`i_mat_idx`/`w_mat_idx` (index phase) pins. Between index commands it waits for the result receiver's completion pulse. It is the stimulus end of the same link the chip shell receives on.

## Interface
- `ELEM_W`, 8: bits per matrix element, sent MSB first
- `NUM_MAT`, 32: matrices per load (16 input followed by 16 weight)
- `IDX_W`, 4: bits per matrix index, sent MSB first

Ports:
- `clk` input 1: single clock
- `rst_n` input 1: asynchronous, active-low reset
- `cmd_valid` input 1: command offered
- `cmd_ready` output 1: command accepted when high with `cmd_valid`
- `cmd_type` input 1: 0 = load, 1 = index
- `cmd_size` input 2: 0 = 2x2, 1 = 4x4, 2 = 8x8, 3 = illegal
- `cmd_i_idx` input IDX_W: input-matrix index
- `cmd_w_idx` input IDX_W: weight-matrix index
- `elem_valid` input 1: element byte offered
- `elem_ready` output 1: byte accepted when high with `elem_valid`
- `elem_data` input ELEM_W: element, row-major, matrix 0 first
- `rsp_done` input 1: one-cycle pulse from the result receiver after the last output bit
- `in_valid`, `matrix`, `matrix_size[1:0]`, `in_valid2`, `i_mat_idx`, `w_mat_idx` output: serial link to the core
- `busy` output 1: high whenever the state is not IDLE
- `err` output 2: sticky {underrun, bad_size}, cleared on the next command acceptance

## Operation
- FSM: IDLE, PRIME, LOAD, IDX, WAIT, GAP.
- IDLE: `cmd_ready`=1. On accept, latch the fields and clear `err`.
  - Load with size 3: set bad_size, go to GAP, drive nothing.
  - Load with a legal size: go to PRIME.
  - Index: go to IDX.
- PRIME: `elem_ready`=1 until the first byte is taken into the shift register, then go to LOAD.
- LOAD:
  - `in_valid`=1 for exactly NUM_MAT·N²·ELEM_W consecutive cycles, where N = 2/4/8. With the defaults this is 1024, 4096 or 16384 cycles.
  - `matrix` carries the shift-register MSB.
  - `matrix_size` equals the latched size on the first LOAD cycle only and is 0 on all other cycles.
  - A one-entry holding register is refilled through `elem_ready` and transfers to the shifter at each element boundary.
  - If the holding register is empty at a boundary: set underrun, shift zeros for that element, and keep `in_valid` high. `in_valid` never gaps.
  - Surplus bytes are not requested; `elem_ready`=0 after the final element.
  - After the last bit go to GAP.
- IDX: `in_valid2`=1 for IDX_W cycles. `i_mat_idx` and `w_mat_idx` carry the MSB-first bits of the latched indices. Then go to WAIT.
- WAIT: all link outputs 0. Stay until `rsp_done`=1, then go to GAP.
- GAP: one cycle with all link outputs 0, then go to IDLE. This guarantees at least one idle cycle between phases.
- Counters: bit counter 0..ELEM_W-1; element counter of width clog2(NUM_MAT·64); index counter 0..IDX_W-1. All wrap only through a state exit.
- `rsp_done` outside WAIT is ignored.
- `cmd_valid` outside IDLE is held off (`cmd_ready`=0).

## Timing
- All outputs are registered.
- Reset value of every output is 0, including `cmd_ready`. `cmd_ready` rises on the first clock after reset release.
- Assertion of `rst_n` mid-operation immediately (asynchronously) zeroes all link outputs and returns the FSM to IDLE. Any partial transfer is abandoned.
- Load accepted at cycle T with the byte available at T+1: PRIME takes it at T+1 and `in_valid` first goes high at T+2.
- Index accepted at T: `in_valid2` is high on T+1..T+IDX_W.
- `rsp_done` at cycle R: GAP at R+1, IDLE with `cmd_ready`=1 at R+2.
- Simultaneous transfer and refill at a boundary: the holding register hands off and accepts a new byte in the same cycle, so throughput is one byte per ELEM_W cycles.

## Structure
- `mmsa_pkg` holds:
  - the FSM state enum;
  - size encodings (SZ_2, SZ_4, SZ_8, SZ_BAD);
  - `cmd_type` encodings;
  - the defaults for ELEM_W, NUM_MAT and IDX_W;
  - a function mapping size to N².
- Sub-module `mmsa_piso`: ELEM_W-bit parallel-in/serial-out shifter with load, shift and MSB out. It is reused by the index path at width IDX_W.

## Test plan
- Load, size 0, bytes 0x00..0xFF repeating:
  - `in_valid` high for exactly 1024 cycles;
  - `matrix_size`=0 throughout;
  - serial stream equals the bytes MSB first;
  - `err`=0.
- Load, size 2 (8x8): `matrix_size`=2 on the first cycle only, `in_valid` high for 16384 cycles, and the first 16 bits are 0xA5 then 0x3C.
- Index with i=0xB, w=0x4: `in_valid2` high for 4 cycles, `i_mat_idx`=1,0,1,1 and `w_mat_idx`=0,1,0,0. Then `busy` stays high until `rsp_done`, followed by 1 GAP cycle.
- Underrun: withhold `elem_valid` across the 3rd element boundary of a 2x2 load. The result must be 8 zero bits on `matrix`, `in_valid` staying high, and `err`=2'b10.
- Load with size 3: no `in_valid`, `err`=2'b01, `cmd_ready` back at T+2.
- Reset asserted mid-LOAD at bit 500: all outputs 0 immediately. A subsequent load starts cleanly with `matrix_size` on its first cycle.
